// File: rtl/fma_dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding and
// sign-magnitude fixed-point constants used by the datapath, activation and bench code.
package fma_dot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FX_Q    = 15;
    localparam int FX_N    = 32;
    localparam int FX_ONE  = 1 << FX_Q;
    localparam int FX_SIGN = FX_N - 1;

endpackage

// File: rtl/fma_dot_seq_fma.sv
// Combinational sign-magnitude fused multiply-add: y = a + b*c.
// The product magnitude is rounded half-up to Q fraction bits; magnitudes wrap silently.
module fma_dot_seq_fma #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] y
);

    localparam int MW = N - 1;

    logic [2*MW-1:0] prod;
    logic [2*MW-1:0] prod_rnd;
    logic [MW-1:0]   p_mag;
    logic            p_sign;
    logic [MW-1:0]   a_mag;
    logic            a_sign;
    logic [MW-1:0]   s_mag;
    logic            s_sign;

    assign a_mag    = a[MW-1:0];
    assign a_sign   = a[N-1];
    assign p_sign   = b[N-1] ^ c[N-1];
    assign prod     = {{MW{1'b0}}, b[MW-1:0]} * {{MW{1'b0}}, c[MW-1:0]};
    assign prod_rnd = prod + ((2*MW)'(1) << (Q - 1));
    assign p_mag    = MW'(prod_rnd >> Q);

    // Unlike signs subtract the smaller magnitude and keep the larger operand's sign.
    always_comb begin
        s_mag  = '0;
        s_sign = a_sign;
        if (a_sign == p_sign) begin
            s_mag  = a_mag + p_mag;
            s_sign = a_sign;
        end else if (a_mag >= p_mag) begin
            s_mag  = a_mag - p_mag;
            s_sign = a_sign;
        end else begin
            s_mag  = p_mag - a_mag;
            s_sign = p_sign;
        end
    end

    assign y = {s_sign, s_mag};

endmodule

// File: rtl/fma_dot_seq.sv
// Dot-product sequencer: streams operand pairs through one shared fma datapath,
// accumulating bias + sum(b*c), and presents the result on a valid/ready port.
module fma_dot_seq
    import fma_dot_seq_pkg::*;
#(
    parameter int Q       = FX_Q,
    parameter int N       = FX_N,
    parameter int MAX_LEN = 256,
    parameter int CW      = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [N-1:0]  i_bias,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_b,
    input  logic [N-1:0]  i_c,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_result,
    output logic [CW-1:0] o_count,
    output logic          o_len_err,
    output logic          o_busy
);

    state_t          state_reg;
    logic [N-1:0]    acc_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            len_err_reg;
    logic            valid_reg;
    logic            busy_reg;
    logic [N-1:0]    fma_y;

    fma_dot_seq_fma #(
        .Q (Q),
        .N (N)
    ) u_fma (
        .a (acc_reg),
        .b (i_b),
        .c (i_c),
        .y (fma_y)
    );

    assign count_next = count_reg + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            count_reg   <= '0;
            len_err_reg <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        acc_reg     <= i_bias;
                        count_reg   <= '0;
                        len_err_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        acc_reg   <= fma_y;
                        count_reg <= count_next;
                        // An explicit last on the MAX_LEN-th pair is a clean finish, not an error.
                        if (i_last) begin
                            valid_reg <= 1'b1;
                            state_reg <= DONE;
                        end else if (count_next == CW'(MAX_LEN)) begin
                            len_err_reg <= 1'b1;
                            valid_reg   <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_ready   = (state_reg == RUN);
    assign o_valid   = valid_reg;
    assign o_result  = acc_reg;
    assign o_count   = count_reg;
    assign o_len_err = len_err_reg;
    assign o_busy    = busy_reg;

endmodule

// File: doc/fma_dot_seq.md
Name: fma_dot_seq

Overview:
Sequencer that time-multiplexes one combinational fma datapath to compute a fixed-point dot product with bias: result = bias + sum(b_i * c_i) over a streamed vector of operand pairs. Operand pairs arrive on a valid/ready stream and the result leaves on a valid/ready port. It sits between the operand buffer/DMA and the downstream activation stage. The number format is sign-magnitude fixed point: MSB is the sign, the low Q bits are the fraction.

Parameters:
Q, 15, fractional bits of the fixed-point format
N, 32, total word width including sign bit
MAX_LEN, 256, maximum vector length accepted before forced termination
CW, 9, element counter width, must satisfy 2^CW > MAX_LEN

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous reset, active-high
i_start  input  1  start pulse, sampled only in IDLE
i_bias  input  N  initial accumulator value, captured with i_start
i_valid  input  1  operand pair valid
o_ready  output  1  sequencer accepts operand pair
i_b  input  N  multiplier operand
i_c  input  N  multiplicand operand
i_last  input  1  marks final pair of the vector
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_result  output  N  dot-product result
o_count  output  CW  number of pairs accumulated into o_result
o_len_err  output  1  vector hit MAX_LEN without i_last; qualified by o_valid
o_busy  output  1  high in RUN or DONE

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst). All state is updated on the rising edge of i_clk.
- Reset values: state=IDLE, acc=0, count=0, o_valid=0, o_ready=0, o_len_err=0, o_busy=0, o_result=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 -> acc<=i_bias, count<=0, len_err<=0, go to RUN.
  - Stream inputs are ignored in IDLE. o_ready=0.
- RUN:
  - o_ready=1 (combinational from state). A pair is accepted on i_valid&&o_ready.
  - Each accepted pair: acc <= fma(a=acc, b=i_b, c=i_c), i.e. acc + i_b*i_c, using the fma rounding and truncation rules unchanged. count<=count+1. Throughput is one pair per cycle.
  - Accepted pair with i_last=1 -> go to DONE.
  - Accepted pair without i_last, when count+1==MAX_LEN -> len_err<=1 and go to DONE. Further pairs stay un-accepted because o_ready drops.
  - i_valid=0 -> no change. Bubbles are allowed indefinitely.
  - i_start is ignored in RUN and DONE.
- DONE:
  - o_valid=1, o_result=acc, o_count=count, o_len_err=len_err. All outputs are held stable until i_valid... handshake completes, i.e. until i_ready=1.
  - i_ready=1 -> go to IDLE. o_valid falls the next cycle.
  - An i_start in the same cycle as the handshake is ignored; the earliest new start is the following cycle.
- Latency: o_valid is asserted the cycle after the last pair is accepted.
  - Minimum start-to-result time is L+1 cycles for L pairs with no bubbles.
  - Minimum result-to-next-start time is 1 cycle.
- Arithmetic:
  - Multiply and add overflow are not detected. Results wrap per the fma datapath; software keeps |partial sums| < 2^(N-1-Q).
  - Negative zero may appear and is treated as zero by consumers.
- Reset mid-operation: any state returns to IDLE, the partial accumulation is discarded, and o_valid drops the next cycle.
- o_busy = (state != IDLE).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and fixed-point constants FX_ONE=1<<Q and FX_SIGN=N-1, for reuse by the activation and bench code.
- Exactly one fma instance with parameters (Q,N). Its a port is driven by acc, and b/c are driven straight from i_b/i_c.
- No further sub-modules. The FSM, counter and accumulator register live in fma_dot_seq.

Test Plan:
- Basic: bias=0x00008000 (1.0), pairs (0x00010000,0x00004000),(0x00010000,0x00010000 last), no bubbles -> o_valid exactly 3 cycles after start, o_result=0x00030000 (6.0), o_count=2, o_len_err=0.
- Negative: bias=0, single pair (0x80008000,0x00008000, last) -> o_result=0x80008000 (-1.0), o_count=1.
- Bubbles and backpressure: i_valid toggled every other cycle on a 4-pair vector of 1.0*1.0 with bias 0, i_ready held low 5 cycles -> o_result=0x00020000 (4.0) held stable while waiting; handshake lands on the first cycle i_ready=1.
- Length error: MAX_LEN=4, 6 pairs of 1.0*1.0 with no i_last -> exactly 4 accepted (o_ready low after the 4th), o_result=0x00020000, o_count=4, o_len_err=1.
- Ignored start: i_start pulses in RUN with i_bias=0x7FFFFFFF, and in DONE during the handshake cycle -> accumulation unaffected and no new vector begins until IDLE.
- Reset mid-run: i_rst asserted after 2 of 4 pairs -> next cycle IDLE, o_valid=0, o_ready=0; a fresh start then yields the correct result without the stale partial sum.
